// File: rtl/sad_search_ctrl.sv
// rtl/sad_search_ctrl.sv - SAD motion-search sequencer: fetches window and frame words, tracks minimum SAD
// A start accepted at edge 0 is staged for one cycle so the fetch sequence begins at edge 1.
module sad_search_ctrl (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        start,
   input  logic [31:0] window_base,
   input  logic [31:0] frame_base,
   input  logic [15:0] frame_len,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   output logic        window_shift,
   output logic        frame_shift,
   input  logic [31:0] SAD_value,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] min_sad,
   output logic [15:0] min_index
);

   typedef enum logic [2:0] {IDLE, WIN, FRM, DRAIN, DONE} state_t;

   state_t      state_q, state_d;
   logic        go_q, go_d;
   logic [31:0] wbase_q, wbase_d;
   logic [31:0] fbase_q, fbase_d;
   logic [15:0] len_q, len_d;
   logic [15:0] cnt_q, cnt_d;
   logic        mem_rd_q, mem_rd_d;
   logic        rd_frm_q, rd_frm_d;
   logic [31:0] addr_q, addr_d;
   logic        win_shift_q, win_shift_d;
   logic        frm_shift_q, frm_shift_d;
   logic [15:0] fidx_q, fidx_d;
   logic [31:0] best_q, best_d;
   logic [15:0] best_idx_q, best_idx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] min_sad_q, min_sad_d;
   logic [15:0] min_index_q, min_index_d;

   always_comb begin
      state_d     = state_q;
      go_d        = go_q;
      wbase_d     = wbase_q;
      fbase_d     = fbase_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      mem_rd_d    = mem_rd_q;
      rd_frm_d    = rd_frm_q;
      addr_d      = addr_q;
      fidx_d      = fidx_q;
      best_d      = best_q;
      best_idx_d  = best_idx_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;
      min_sad_d   = min_sad_q;
      min_index_d = min_index_q;

      // Shift enables follow the read they belong to by one cycle (read data latency).
      win_shift_d = mem_rd_q & ~rd_frm_q;
      frm_shift_d = mem_rd_q & rd_frm_q;

      if (frm_shift_q) begin
         fidx_d = fidx_q + 16'd1;
         if (fidx_q >= 16'd3 && SAD_value < best_q) begin
            best_d     = SAD_value;
            best_idx_d = fidx_q - 16'd3;
         end
      end

      case (state_q)
         IDLE: begin
            if (go_q) begin
               go_d = 1'b0;
               if (len_q < 16'd4) begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  err_d       = 1'b1;
                  min_sad_d   = 32'hFFFF_FFFF;
                  min_index_d = 16'd0;
               end else begin
                  state_d  = WIN;
                  mem_rd_d = 1'b1;
                  rd_frm_d = 1'b0;
                  addr_d   = wbase_q;
                  cnt_d    = 16'd0;
                  busy_d   = 1'b1;
               end
            end else if (start) begin
               go_d       = 1'b1;
               wbase_d    = window_base;
               fbase_d    = frame_base;
               len_d      = frame_len;
               fidx_d     = 16'd0;
               best_d     = 32'hFFFF_FFFF;
               best_idx_d = 16'd0;
            end
         end
         WIN: begin
            if (cnt_q == 16'd3) begin
               state_d  = FRM;
               rd_frm_d = 1'b1;
               addr_d   = fbase_q;
               cnt_d    = 16'd0;
            end else begin
               addr_d = addr_q + 32'd4;
               cnt_d  = cnt_q + 16'd1;
            end
         end
         FRM: begin
            if (cnt_q == len_q - 16'd1) begin
               state_d  = DRAIN;
               mem_rd_d = 1'b0;
               rd_frm_d = 1'b0;
               addr_d   = 32'd0;
            end else begin
               addr_d = addr_q + 32'd4;
               cnt_d  = cnt_q + 16'd1;
            end
         end
         DRAIN: begin
            // The last candidate is evaluated in this cycle, so publish the merged result.
            state_d     = DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            err_d       = 1'b0;
            min_sad_d   = best_d;
            min_index_d = best_idx_d;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         go_q        <= 1'b0;
         wbase_q     <= 32'd0;
         fbase_q     <= 32'd0;
         len_q       <= 16'd0;
         cnt_q       <= 16'd0;
         mem_rd_q    <= 1'b0;
         rd_frm_q    <= 1'b0;
         addr_q      <= 32'd0;
         win_shift_q <= 1'b0;
         frm_shift_q <= 1'b0;
         fidx_q      <= 16'd0;
         best_q      <= 32'd0;
         best_idx_q  <= 16'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         min_sad_q   <= 32'd0;
         min_index_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         go_q        <= go_d;
         wbase_q     <= wbase_d;
         fbase_q     <= fbase_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         mem_rd_q    <= mem_rd_d;
         rd_frm_q    <= rd_frm_d;
         addr_q      <= addr_d;
         win_shift_q <= win_shift_d;
         frm_shift_q <= frm_shift_d;
         fidx_q      <= fidx_d;
         best_q      <= best_d;
         best_idx_q  <= best_idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         min_sad_q   <= min_sad_d;
         min_index_q <= min_index_d;
      end
   end

   assign mem_rd       = mem_rd_q;
   assign mem_addr     = addr_q;
   assign window_shift = win_shift_q;
   assign frame_shift  = frm_shift_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;
   assign min_sad      = min_sad_q;
   assign min_index    = min_index_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb/tb_sad_search_ctrl.sv - self-checking bench for sad_search_ctrl with memory and SAD datapath model
module tb_sad_search_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] window_base = 32'd0;
   logic [31:0] frame_base = 32'd0;
   logic [15:0] frame_len = 16'd0;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic        window_shift;
   logic        frame_shift;
   logic [31:0] SAD_value;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] min_sad;
   logic [15:0] min_index;

   sad_search_ctrl dut (
      .Clk(Clk), .Reset(Reset), .start(start), .window_base(window_base),
      .frame_base(frame_base), .frame_len(frame_len), .mem_rd(mem_rd),
      .mem_addr(mem_addr), .window_shift(window_shift), .frame_shift(frame_shift),
      .SAD_value(SAD_value), .busy(busy), .done(done), .err(err),
      .min_sad(min_sad), .min_index(min_index)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Memory image and SAD datapath
   logic [31:0] tb_wbase, tb_fbase;
   logic [31:0] tb_win [4];
   logic [31:0] tb_frm [16];
   logic [31:0] rd_data = 32'd0;
   logic [31:0] win_reg [4] = '{default: 32'd0};
   logic [31:0] frm_reg [4] = '{default: 32'd0};

   function automatic logic [31:0] sad4(input logic [127:0] a, input logic [127:0] b);
      logic [31:0] s;
      s = 32'd0;
      for (int k = 0; k < 16; k++) begin
         if (a[8*k +: 8] > b[8*k +: 8]) s = s + 32'(a[8*k +: 8] - b[8*k +: 8]);
         else                           s = s + 32'(b[8*k +: 8] - a[8*k +: 8]);
      end
      return s;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] off;
      off = a - tb_wbase;
      if (off < 32'd16) return tb_win[off[3:2]];
      off = a - tb_fbase;
      if (off < 32'd64) return tb_frm[off[5:2]];
      return 32'd0;
   endfunction

   always @(posedge Clk) begin
      rd_data <= mem_rd ? mem_word(mem_addr) : 32'd0;
      if (window_shift) begin
         win_reg[0] <= win_reg[1]; win_reg[1] <= win_reg[2];
         win_reg[2] <= win_reg[3]; win_reg[3] <= rd_data;
      end
      if (frame_shift) begin
         frm_reg[0] <= frm_reg[1]; frm_reg[1] <= frm_reg[2];
         frm_reg[2] <= frm_reg[3]; frm_reg[3] <= rd_data;
      end
   end

   assign SAD_value = sad4({win_reg[0], win_reg[1], win_reg[2], win_reg[3]},
                           {frm_reg[1], frm_reg[2], frm_reg[3], rd_data});

   // Scoreboard
   typedef struct {
      logic [31:0] sad;
      logic [15:0] idx;
      logic        err;
      int          done_cyc;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   task automatic push_expected(input int n);
      exp_t x;
      logic [31:0] s;
      x.sad = 32'hFFFF_FFFF;
      x.idx = 16'd0;
      x.err = (n < 4);
      x.done_cyc = (n < 4) ? 1 : n + 6;
      for (int i = 0; i + 3 < n; i++) begin
         s = sad4({tb_win[0], tb_win[1], tb_win[2], tb_win[3]},
                  {tb_frm[i], tb_frm[i+1], tb_frm[i+2], tb_frm[i+3]});
         if (s < x.sad) begin
            x.sad = s;
            x.idx = 16'(i);
         end
      end
      sb.push_back(x);
   endtask

   // Per-cycle observation logs
   logic        log_rd   [64];
   logic [31:0] log_addr [64];
   logic        log_ws   [64];
   logic        log_fs   [64];
   logic        log_busy [64];
   logic [88:0] log_all  [64];
   int          done_cnt;
   int          done_at;
   logic [31:0] got_sad;
   logic [15:0] got_idx;
   logic        got_err;

   // Caller must be at a negedge; start is sampled at the following edge 0.
   task automatic run(input logic [31:0] wb, input logic [31:0] fb, input logic [15:0] n,
                      input int abort_cyc, input int busy_start_cyc, input int ncyc);
      window_base = wb; frame_base = fb; frame_len = n;
      tb_wbase = wb; tb_fbase = fb;
      done_cnt = 0; done_at = -1;
      for (int c = 0; c < 64; c++) begin
         log_rd[c] = 0; log_addr[c] = 0; log_ws[c] = 0; log_fs[c] = 0; log_busy[c] = 0; log_all[c] = '0;
      end
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      window_base = 32'hDEAD_0000; frame_base = 32'hBEEF_0000; frame_len = 16'd2;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge Clk);
         start = (c == busy_start_cyc);
         if (c == abort_cyc) begin
            Reset = 1'b0;
            #1;
         end
         log_rd[c] = mem_rd; log_addr[c] = mem_addr; log_ws[c] = window_shift;
         log_fs[c] = frame_shift; log_busy[c] = busy;
         log_all[c] = {mem_rd, mem_addr, window_shift, frame_shift, busy, done, err, min_sad, min_index};
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) begin
               done_at = c; got_sad = min_sad; got_idx = min_index; got_err = err;
            end
         end
      end
      start = 1'b0;
   endtask

   task automatic check_result(input string tag);
      if (sb.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s_scoreboard: got empty queue, want one entry", tag);
         return;
      end
      e = sb.pop_front();
      n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL %s_done_count: got %0d want 1", tag, done_cnt); end
      n_cmp++; if (done_at !== e.done_cyc) begin n_bad++; $display("FAIL %s_done_cycle: got %0d want %0d", tag, done_at, e.done_cyc); end
      n_cmp++; if (got_sad !== e.sad) begin n_bad++; $display("FAIL %s_min_sad: got %h want %h", tag, got_sad, e.sad); end
      n_cmp++; if (got_idx !== e.idx) begin n_bad++; $display("FAIL %s_min_index: got %0d want %0d", tag, got_idx, e.idx); end
      n_cmp++; if (got_err !== e.err) begin n_bad++; $display("FAIL %s_err: got %b want %b", tag, got_err, e.err); end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      #2 Reset = 1'b0;
      repeat (3) @(negedge Clk);
      n_cmp++; if ({mem_rd, mem_addr, window_shift, frame_shift} !== 35'd0) begin n_bad++; $display("FAIL reset_mem: got %h want 0", {mem_rd, mem_addr, window_shift, frame_shift}); end
      n_cmp++; if ({busy, done, err} !== 3'd0) begin n_bad++; $display("FAIL reset_status: got %b want 000", {busy, done, err}); end
      n_cmp++; if ({min_sad, min_index} !== 48'd0) begin n_bad++; $display("FAIL reset_min: got %h want 0", {min_sad, min_index}); end
      Reset = 1'b1;
   endtask

   task automatic setup_basic();
      for (int k = 0; k < 4; k++) tb_win[k] = 32'h1010_1010;
      for (int j = 0; j < 16; j++) tb_frm[j] = 32'd0;
      for (int j = 1; j <= 4; j++) tb_frm[j] = 32'h1010_1010;
   endtask

   task automatic test_basic();
      int bad;
      setup_basic();
      push_expected(6);
      run(32'h1000, 32'h2000, 16'd6, 0, 0, 16);
      n_cmp++; if (sb[0].sad !== 32'd0 || sb[0].idx !== 16'd1) begin n_bad++; $display("FAIL basic_model: got %0d/%0d want 0/1", sb[0].sad, sb[0].idx); end
      n_cmp++; if (done_at !== 12) begin n_bad++; $display("FAIL basic_done12: got %0d want 12", done_at); end
      check_result("basic");
      bad = 0;
      for (int c = 1; c <= 16; c++) begin
         if (log_ws[c] !== (c >= 2 && c <= 5)) bad++;
         if (log_fs[c] !== (c >= 6 && c <= 11)) bad++;
         if (log_busy[c] !== (c <= 11)) bad++;
         if (!log_rd[c] && log_addr[c] !== 32'd0) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL basic_cycles: got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_tie();
      for (int k = 0; k < 4; k++) tb_win[k] = 32'h1010_1010;
      for (int j = 0; j < 16; j++) tb_frm[j] = 32'd0;
      push_expected(7);
      run(32'h40, 32'h800, 16'd7, 0, 0, 16);
      n_cmp++; if (got_sad !== 32'd256) begin n_bad++; $display("FAIL tie_sad256: got %0d want 256", got_sad); end
      check_result("tie");
   endtask

   task automatic test_short();
      int bad;
      for (int j = 0; j < 16; j++) tb_frm[j] = $urandom;
      push_expected(3);
      run(32'h40, 32'h800, 16'd3, 0, 0, 8);
      check_result("short");
      bad = 0;
      for (int c = 1; c <= 8; c++) if (log_rd[c] !== 1'b0 || log_ws[c] !== 1'b0 || log_fs[c] !== 1'b0) bad++;
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL short_no_access: got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_timing();
      logic [31:0] exp_addr [8];
      int bad;
      exp_addr = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
      for (int k = 0; k < 4; k++) tb_win[k] = $urandom;
      for (int j = 0; j < 16; j++) tb_frm[j] = $urandom;
      push_expected(4);
      run(32'h100, 32'hFFFF_FFF8, 16'd4, 0, 0, 14);
      bad = 0;
      for (int c = 1; c <= 8; c++) if (log_rd[c] !== 1'b1 || log_addr[c] !== exp_addr[c-1]) bad++;
      if (log_rd[9] !== 1'b0 || log_addr[9] !== 32'd0) bad++;
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL timing_addr_seq: got %0d bad cycles want 0", bad); end
      bad = 0;
      for (int c = 1; c <= 14; c++) begin
         if (log_ws[c] !== (c >= 2 && c <= 5)) bad++;
         if (log_fs[c] !== (c >= 6 && c <= 9)) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL timing_shifts: got %0d bad cycles want 0", bad); end
      check_result("timing");
   endtask

   task automatic test_abort();
      setup_basic();
      run(32'h1000, 32'h2000, 16'd6, 7, 0, 14);
      n_cmp++; if (log_busy[6] !== 1'b1) begin n_bad++; $display("FAIL abort_busy_before: got %b want 1", log_busy[6]); end
      n_cmp++; if (log_all[7] !== '0) begin n_bad++; $display("FAIL abort_outputs_zero: got %h want 0", log_all[7]); end
      n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
      Reset = 1'b1;
      push_expected(6);
      run(32'h1000, 32'h2000, 16'd6, 0, 0, 16);
      check_result("abort_rerun");
   endtask

   task automatic test_start_busy();
      setup_basic();
      push_expected(6);
      run(32'h1000, 32'h2000, 16'd6, 0, 3, 24);
      check_result("start_busy");
   endtask

   task automatic test_back_to_back();
      int n;
      for (int t = 0; t < 4; t++) begin
         n = 5 + 2 * t;
         for (int k = 0; k < 4; k++) tb_win[k] = $urandom;
         for (int j = 0; j < 16; j++) tb_frm[j] = $urandom;
         push_expected(n);
         run($urandom & 32'hFFFF_FF00, 32'hFFFF_FF00 + ($urandom_range(0, 60) * 4), 16'(n), 0, 0, n + 7);
         check_result($sformatf("b2b%0d", t));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish want finish before 200000");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_short();
      test_timing();
      test_abort();
      test_start_busy();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
